// File: rtl/ebus_pkg.sv
// Shared types and default timing for the external Z80 bus master arbiter.
//   ebus_state_e : arbiter FSM states
//   req_idx_t    : requester index (port 0 = SPI master, port 1 = DMA engine)
//   ebus_req_t   : per-access payload latched on entry to SETUP
package ebus_pkg;

  localparam int unsigned N_REQ  = 2;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam int unsigned T_SETUP_DEF     = 2;
  localparam int unsigned T_STROBE_DEF    = 6;
  localparam int unsigned T_HOLD_DEF      = 2;
  localparam int unsigned T_LINGER_DEF    = 16;
  localparam int unsigned ACK_TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_BUS,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_LINGER,
    ST_FAIL,
    ST_RELEASE
  } ebus_state_e;

  typedef logic req_idx_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrdata;
    logic              wr;
    logic              io;
  } ebus_req_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ebus_rr_sel.sv
// Two-input round-robin selector with post-ack masking.
//   req    : raw level requests
//   ack    : registered ack pulses; the acked port is masked during the ack
//            cycle and the cycle after, so a stale level req is not re-taken
//   take   : selection is consumed this cycle (updates last_grant)
//   pend_c : masked requests, any_c : any pending, sel_c : winner
module ebus_rr_sel
  import ebus_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] ack,
  input  logic             take,
  output logic [N_REQ-1:0] pend_c,
  output logic             any_c,
  output req_idx_t         sel_c
);

  req_idx_t         last_grant_q;
  logic [N_REQ-1:0] mask_q;

  assign pend_c = req & ~(ack | mask_q);
  assign any_c  = |pend_c;

  // Both pending: alternate away from the last winner.
  always_comb begin
    sel_c = req_idx_t'(0);
    if (pend_c == 2'b11) begin
      sel_c = ~last_grant_q;
    end else if (pend_c[1]) begin
      sel_c = req_idx_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= req_idx_t'(1);
      mask_q       <= '0;
    end else begin
      mask_q <= ack;
      if (take && any_c) begin
        last_grant_q <= sel_c;
      end
    end
  end

endmodule

// File: rtl/ebus_master_arb.sv
// External Z80 bus master: arbitrates two requesters, acquires the bus via
// BUSREQ/BUSACK, runs timed memory/IO cycles, lingers before release.
//   rN_*        : requester ports (level req held until one-cycle ack; err
//                 qualifies ack when the access was not performed)
//   bus_busreq  : request the bus; bus_busack_n is asynchronous
//   bus_en      : drive address/control; bus_wrdata_en drives data
//   bus_*_n     : active-low strobes
//   busy        : arbiter not idle
module ebus_master_arb
  import ebus_pkg::*;
#(
  parameter int unsigned T_SETUP     = T_SETUP_DEF,
  parameter int unsigned T_STROBE    = T_STROBE_DEF,
  parameter int unsigned T_HOLD      = T_HOLD_DEF,
  parameter int unsigned T_LINGER    = T_LINGER_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wrdata,
  input  logic              r0_wr,
  input  logic              r0_io,
  output logic              r0_ack,
  output logic              r0_err,
  output logic [DATA_W-1:0] r0_rddata,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wrdata,
  input  logic              r1_wr,
  input  logic              r1_io,
  output logic              r1_ack,
  output logic              r1_err,
  output logic [DATA_W-1:0] r1_rddata,
  output logic              bus_busreq,
  input  logic              bus_busack_n,
  output logic              bus_en,
  output logic [ADDR_W-1:0] bus_a,
  output logic              bus_rd_n,
  output logic              bus_wr_n,
  output logic              bus_mreq_n,
  output logic              bus_iorq_n,
  output logic [DATA_W-1:0] bus_wrdata,
  output logic              bus_wrdata_en,
  input  logic [DATA_W-1:0] bus_rddata,
  output logic              busy
);

  localparam int unsigned T_MAX = max_u(max_u(max_u(T_SETUP, T_STROBE),
                                              max_u(T_HOLD, T_LINGER)), ACK_TIMEOUT);
  localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t SETUP_LAST  = CNT_W'(T_SETUP - 1);
  localparam cnt_t STROBE_LAST = CNT_W'(T_STROBE - 1);
  localparam cnt_t HOLD_LAST   = CNT_W'(T_HOLD - 1);
  localparam cnt_t LINGER_LAST = CNT_W'(T_LINGER - 1);
  localparam cnt_t ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);

  ebus_state_e      state_q, state_d;
  cnt_t             cnt_q, cnt_d, cnt_inc;
  ebus_req_t        cur_q, cur_d;
  req_idx_t         sel_q, sel_d;
  ebus_req_t        req_fld [N_REQ];
  logic [N_REQ-1:0] req_vec;
  logic [N_REQ-1:0] pend_c;
  logic             any_c;
  req_idx_t         sel_c;
  logic             take;
  logic             abort;
  logic             viol;
  logic             cap_rd;
  logic             busack_s1, busack_sync;
  logic [DATA_W-1:0] rd_hold_q;
  logic [DATA_W-1:0] rddata_q [N_REQ];
  logic [N_REQ-1:0] ack_q, ack_d, err_q, err_d;
  logic             en_d, breq_d, acc_d, rd_n_d, wr_n_d, mreq_n_d, iorq_n_d, wden_d;

  assign req_vec    = {r1_req, r0_req};
  assign req_fld[0] = '{addr: r0_addr, wrdata: r0_wrdata, wr: r0_wr, io: r0_io};
  assign req_fld[1] = '{addr: r1_addr, wrdata: r1_wrdata, wr: r1_wr, io: r1_io};
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  ebus_rr_sel u_sel (
    .clk    (clk),
    .reset  (reset),
    .req    (req_vec),
    .ack    (ack_q),
    .take   (take),
    .pend_c (pend_c),
    .any_c  (any_c),
    .sel_c  (sel_c)
  );

  // BUSACK synchroniser; idle level is high (not acknowledged).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busack_s1   <= 1'b1;
      busack_sync <= 1'b1;
    end else begin
      busack_s1   <= bus_busack_n;
      busack_sync <= busack_s1;
    end
  end

  // Next state, latched access and next values of all registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    sel_d   = sel_q;
    take    = 1'b0;
    abort   = 1'b0;
    ack_d   = '0;
    err_d   = '0;
    viol    = busack_sync &&
              (state_q inside {ST_SETUP, ST_STROBE, ST_HOLD, ST_LINGER});
    cap_rd  = (state_q == ST_STROBE) && (cnt_q == STROBE_LAST) && !cur_q.wr && !viol;

    unique case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          state_d = ST_REQ_BUS;
          cnt_d   = '0;
        end
      end
      ST_REQ_BUS: begin
        if (!busack_sync) begin
          cnt_d = '0;
          if (any_c) begin
            state_d = ST_SETUP;
            take    = 1'b1;
          end else begin
            state_d = ST_LINGER;
          end
        end else if (cnt_q == ACK_LAST) begin
          state_d = ST_FAIL;
          ack_d   = pend_c;
          err_d   = pend_c;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_SETUP: begin
        if (viol) begin
          state_d = ST_RELEASE;
          abort   = 1'b1;
        end else if (cnt_q == SETUP_LAST) begin
          state_d = ST_STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_STROBE: begin
        if (viol) begin
          state_d = ST_RELEASE;
          abort   = 1'b1;
        end else if (cnt_q == STROBE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HOLD: begin
        if (viol) begin
          // On the final HOLD cycle the normal ack is already out.
          state_d = ST_RELEASE;
          abort   = (cnt_q != HOLD_LAST);
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (any_c) begin
            state_d = ST_SETUP;
            take    = 1'b1;
          end else begin
            state_d = ST_LINGER;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_LINGER: begin
        if (viol) begin
          state_d = ST_RELEASE;
        end else if (any_c) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          take    = 1'b1;
        end else if (cnt_q == LINGER_LAST) begin
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_FAIL: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (busack_sync) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (take) begin
      sel_d = sel_c;
      cur_d = req_fld[sel_c];
    end
    if (abort) begin
      ack_d[sel_q] = 1'b1;
      err_d[sel_q] = 1'b1;
    end
    if ((state_d == ST_HOLD) && (cnt_d == HOLD_LAST)) begin
      ack_d[sel_q] = 1'b1;
    end

    en_d     = state_d inside {ST_SETUP, ST_STROBE, ST_HOLD, ST_LINGER};
    breq_d   = en_d || (state_d == ST_REQ_BUS);
    acc_d    = (state_d inside {ST_SETUP, ST_STROBE}) ||
               ((state_d == ST_HOLD) && (cnt_d != HOLD_LAST));
    mreq_n_d = !(acc_d && !cur_d.io);
    iorq_n_d = !(acc_d && cur_d.io);
    rd_n_d   = !((state_d == ST_STROBE) && !cur_d.wr);
    wr_n_d   = !((state_d == ST_STROBE) && cur_d.wr);
    wden_d   = cur_d.wr && (state_d inside {ST_SETUP, ST_STROBE, ST_HOLD});
  end

  // State, access latch and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cur_q         <= '0;
      sel_q         <= req_idx_t'(0);
      rd_hold_q     <= '0;
      rddata_q[0]   <= '0;
      rddata_q[1]   <= '0;
      ack_q         <= '0;
      err_q         <= '0;
      bus_en        <= 1'b0;
      bus_busreq    <= 1'b0;
      bus_rd_n      <= 1'b1;
      bus_wr_n      <= 1'b1;
      bus_mreq_n    <= 1'b1;
      bus_iorq_n    <= 1'b1;
      bus_wrdata_en <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_q         <= cur_d;
      sel_q         <= sel_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      bus_en        <= en_d;
      bus_busreq    <= breq_d;
      bus_rd_n      <= rd_n_d;
      bus_wr_n      <= wr_n_d;
      bus_mreq_n    <= mreq_n_d;
      bus_iorq_n    <= iorq_n_d;
      bus_wrdata_en <= wden_d;
      busy          <= (state_d != ST_IDLE);
      if (cap_rd) begin
        rd_hold_q <= bus_rddata;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (ack_d[i] && !err_d[i] && !cur_q.wr) begin
          rddata_q[i] <= rd_hold_q;
        end
      end
    end
  end

  assign bus_a      = cur_q.addr;
  assign bus_wrdata = cur_q.wrdata;
  assign r0_ack     = ack_q[0];
  assign r1_ack     = ack_q[1];
  assign r0_err     = err_q[0];
  assign r1_err     = err_q[1];
  assign r0_rddata  = rddata_q[0];
  assign r1_rddata  = rddata_q[1];

endmodule

// File: tb/tb_ebus_master_arb.sv
// Directed self-checking bench for ebus_master_arb with a simple Z80 BUSACK model.
module tb_ebus_master_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_wr, r0_io, r0_ack, r0_err;
  logic [15:0] r0_addr;
  logic [7:0]  r0_wrdata, r0_rddata;
  logic        r1_req, r1_wr, r1_io, r1_ack, r1_err;
  logic [15:0] r1_addr;
  logic [7:0]  r1_wrdata, r1_rddata;
  logic        bus_busreq, bus_busack_n, bus_en;
  logic [15:0] bus_a;
  logic        bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n, bus_wrdata_en, busy;
  logic [7:0]  bus_wrdata, bus_rddata;

  int n_checks = 0;
  int n_errors = 0;
  int z80_mode = 0;   // 0: grant after 5 cycles, 1: BUSACK held high
  int z_cnt    = 0;
  int rd_lo = 0, wr_lo = 0, mr_lo = 0, io_lo = 0, wden = 0, breq_rise = 0;
  logic breq_prev = 1'b0;

  ebus_master_arb dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_wrdata(r0_wrdata), .r0_wr(r0_wr), .r0_io(r0_io),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rddata(r0_rddata),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_wrdata(r1_wrdata), .r1_wr(r1_wr), .r1_io(r1_io),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rddata(r1_rddata),
    .bus_busreq(bus_busreq), .bus_busack_n(bus_busack_n), .bus_en(bus_en), .bus_a(bus_a),
    .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n), .bus_mreq_n(bus_mreq_n), .bus_iorq_n(bus_iorq_n),
    .bus_wrdata(bus_wrdata), .bus_wrdata_en(bus_wrdata_en), .bus_rddata(bus_rddata), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Z80 model: pulls BUSACK low 5 cycles after seeing BUSREQ, releases when it drops.
  initial begin
    bus_busack_n = 1'b1;
    forever begin
      @(negedge clk);
      if (z80_mode != 0 || !bus_busreq) begin
        bus_busack_n = 1'b1;
        z_cnt = 0;
      end else if (z_cnt < 5) begin
        z_cnt++;
      end else begin
        bus_busack_n = 1'b0;
      end
    end
  end

  // Bus activity counters sampled just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (!bus_rd_n)     rd_lo++;
    if (!bus_wr_n)     wr_lo++;
    if (!bus_mreq_n)   mr_lo++;
    if (!bus_iorq_n)   io_lo++;
    if (bus_wrdata_en) wden++;
    if (bus_busreq && !breq_prev) breq_rise++;
    breq_prev = bus_busreq;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_any(input int budget, output int cyc, output logic a0, output logic a1);
    cyc = 0; a0 = 1'b0; a1 = 1'b0;
    while (cyc < budget && !a0 && !a1) begin
      @(negedge clk);
      cyc++;
      a0 = r0_ack;
      a1 = r1_ack;
    end
  endtask

  task automatic wait_idle(input int budget, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = !busy;
    end
  endtask

  task automatic wait_strobe(input int budget, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = !bus_rd_n;
    end
  endtask

  int cyc, s_rd, s_wr, s_mr, s_io, s_wd, s_br, n0, n1, nl;
  logic a0, a1, ok, stop;
  logic [7:0] hist;

  initial begin
    reset = 1'b1;
    r0_req = 0; r0_addr = '0; r0_wrdata = '0; r0_wr = 0; r0_io = 0;
    r1_req = 0; r1_addr = '0; r1_wrdata = '0; r1_wr = 0; r1_io = 0;
    bus_rddata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busreq", 32'(bus_busreq), 0);
    chk("rst_en", 32'(bus_en), 0);
    chk("rst_strobes", 32'({bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n}), 32'hF);
    chk("rst_wden", 32'(bus_wrdata_en), 0);
    chk("rst_acks", 32'({r0_ack, r0_err, r1_ack, r1_err}), 0);
    chk("rst_rddata", 32'({r0_rddata, r1_rddata}), 0);
    chk("rst_addr", 32'(bus_a), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    @(negedge clk);

    // Port 0 memory read from IDLE.
    bus_rddata = 8'hA5;
    s_rd = rd_lo; s_mr = mr_lo; s_br = breq_rise;
    r0_addr = 16'h1234; r0_wr = 0; r0_io = 0; r0_req = 1;
    wait_any(100, cyc, a0, a1);
    chk("rd_ack", 32'(a0), 1);
    chk("rd_lat", 32'(cyc), 18);
    chk("rd_err", 32'(r0_err), 0);
    chk("rd_data", 32'(r0_rddata), 32'hA5);
    chk("rd_addr", 32'(bus_a), 32'h1234);
    r0_req = 0;
    @(negedge clk);
    chk("rd_ack_pulse", 32'(r0_ack), 0);
    chk("rd_rdn_cycles", 32'(rd_lo - s_rd), 6);
    chk("rd_mreq_cycles", 32'(mr_lo - s_mr), 9);
    chk("rd_busreq_rise", 32'(breq_rise - s_br), 1);

    // Port 1 IO write while bus lingers.
    s_rd = rd_lo; s_wr = wr_lo; s_mr = mr_lo; s_io = io_lo; s_wd = wden; s_br = breq_rise;
    r1_addr = 16'h00BF; r1_wrdata = 8'h3C; r1_wr = 1; r1_io = 1; r1_req = 1;
    wait_any(40, cyc, a0, a1);
    chk("wr_ack", 32'(a1), 1);
    chk("wr_lat", 32'(cyc), 10);
    chk("wr_err", 32'(r1_err), 0);
    chk("wr_addr", 32'(bus_a), 32'h00BF);
    chk("wr_data", 32'(bus_wrdata), 32'h3C);
    r1_req = 0;
    @(negedge clk);
    chk("wr_wrn_cycles", 32'(wr_lo - s_wr), 6);
    chk("wr_iorq_cycles", 32'(io_lo - s_io), 9);
    chk("wr_wden_cycles", 32'(wden - s_wd), 10);
    chk("wr_no_rd_mreq", 32'((rd_lo - s_rd) + (mr_lo - s_mr)), 0);
    chk("wr_no_rehandshake", 32'(breq_rise - s_br), 0);
    wait_idle(60, ok);
    chk("wr_idle", 32'(ok), 1);

    // Simultaneous burst, four accesses per port.
    s_br = breq_rise; hist = '0; n0 = 0; n1 = 0;
    r0_addr = 16'h2000; r0_wr = 0; r0_io = 0; r0_req = 1;
    r1_addr = 16'h3000; r1_wrdata = 8'h55; r1_wr = 1; r1_io = 0; r1_req = 1;
    for (int k = 0; k < 8; k++) begin
      wait_any(60, cyc, a0, a1);
      chk("burst_ack", 32'(a0 ^ a1), 1);
      if (a0) begin
        hist = {hist[6:0], 1'b0}; n0++;
        if (n0 == 4) r0_req = 0; else r0_addr = r0_addr + 16'd1;
      end else if (a1) begin
        hist = {hist[6:0], 1'b1}; n1++;
        if (n1 == 4) r1_req = 0; else r1_addr = r1_addr + 16'd1;
      end
    end
    r0_req = 0; r1_req = 0;
    nl = 0; stop = 0;
    for (int c = 0; c < 40 && !stop; c++) begin
      @(negedge clk);
      if (bus_busreq && bus_en) nl++; else stop = 1;
    end
    chk("burst_order", 32'(hist), 32'h55);
    chk("burst_linger", 32'(nl), 16);
    chk("burst_release_en", 32'(bus_en), 0);
    chk("burst_busreq_rise", 32'(breq_rise - s_br), 1);
    wait_idle(40, ok);
    chk("burst_idle", 32'(ok), 1);

    // BUSACK never arrives.
    z80_mode = 1;
    s_rd = rd_lo + wr_lo + mr_lo + io_lo;
    r0_addr = 16'h0100; r0_wr = 0; r0_io = 0; r0_req = 1;
    r1_addr = 16'h0200; r1_wr = 0; r1_io = 0; r1_req = 1;
    wait_any(1100, cyc, a0, a1);
    chk("to_ack0", 32'(a0), 1);
    chk("to_lat", 32'(cyc), 1025);
    chk("to_err0", 32'(r0_err), 1);
    chk("to_ack1", 32'({r1_ack, r1_err}), 3);
    chk("to_busreq", 32'(bus_busreq), 0);
    r0_req = 0; r1_req = 0;
    wait_idle(20, ok);
    chk("to_idle", 32'(ok), 1);
    chk("to_no_strobe", 32'(rd_lo + wr_lo + mr_lo + io_lo - s_rd), 0);
    z80_mode = 0;

    // BUSACK withdrawn mid-STROBE.
    s_rd = rd_lo;
    r0_addr = 16'h4000; r0_wr = 0; r0_io = 0; r0_req = 1;
    wait_strobe(60, ok);
    chk("viol_strobe_seen", 32'(ok), 1);
    #1 z80_mode = 1;
    wait_any(20, cyc, a0, a1);
    chk("viol_ack", 32'(a0), 1);
    chk("viol_err", 32'(r0_err), 1);
    chk("viol_en", 32'(bus_en), 0);
    chk("viol_busreq", 32'(bus_busreq), 0);
    chk("viol_rdn", 32'(bus_rd_n), 1);
    r0_req = 0;
    chk("viol_rdn_cycles", 32'(rd_lo - s_rd), 4);
    wait_idle(20, ok);
    chk("viol_idle", 32'(ok), 1);
    z80_mode = 0;

    // Reset mid-STROBE after a port 0 grant, then both request.
    r0_addr = 16'h5000; r0_wr = 0; r0_io = 0; r0_req = 1;
    wait_strobe(60, ok);
    chk("arst_strobe_seen", 32'(ok), 1);
    #2 reset = 1'b1; r0_req = 0;
    #1;
    chk("arst_en", 32'(bus_en), 0);
    chk("arst_busreq", 32'(bus_busreq), 0);
    chk("arst_strobes", 32'({bus_rd_n, bus_mreq_n}), 3);
    chk("arst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    s_br = breq_rise;
    r0_req = 1; r1_addr = 16'h6000; r1_wr = 0; r1_io = 0; r1_req = 1;
    wait_any(100, cyc, a0, a1);
    chk("arst_first_port0", 32'({a0, a1}), 2);
    chk("arst_lat", 32'(cyc), 18);
    r0_req = 0;
    wait_any(40, cyc, a0, a1);
    chk("arst_second_port1", 32'({a0, a1}), 1);
    r1_req = 0;
    chk("arst_busreq_rise", 32'(breq_rise - s_br), 1);
    wait_idle(60, ok);
    chk("arst_idle", 32'(ok), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ebus_master_arb.md
Name: ebus_master_arb

Overview:
- Arbitrates two internal requesters (port 0: SPI bus-master path; port 1: future DMA/copy engine) for the external Z80 bus.
- Obtains the bus through the Z80 BUSREQ/BUSACK handshake and runs timed memory or IO cycles.
- Keeps the bus across back-to-back requests and returns it after an idle linger period.
- Sits between the requesters and the ebus tristate drivers in top. Top turns bus_busreq into open-drain ebus_busreq_n and gates its drivers with bus_en.

Parameters:
- T_SETUP, 2, clk cycles that address, strobe-type and write data are driven before the strobe.
- T_STROBE, 6, clk cycles that rd_n or wr_n is held low.
- T_HOLD, 2, clk cycles that address and data are held after the strobe.
- T_LINGER, 16, idle clk cycles with the bus held before release.
- ACK_TIMEOUT, 1024, clk cycles to wait for busack_n before failing.

Ports:
- clk  in  1  system clock (28.63636 MHz)
- reset  in  1  asynchronous, active-high
- rN_req  in  1  request, N=0,1. Level; held until rN_ack.
- rN_addr  in  16  address
- rN_wrdata  in  8  write data
- rN_wr  in  1  1=write, 0=read
- rN_io  in  1  1=IO cycle (iorq_n), 0=memory cycle (mreq_n)
- rN_ack  out  1  one-cycle completion pulse
- rN_err  out  1  qualifies rN_ack: bus not granted, access not performed
- rN_rddata  out  8  read data, valid from rN_ack until the next ack on that port
- bus_busreq  out  1  request bus from Z80
- bus_busack_n  in  1  Z80 BUSACK, asynchronous; 2-flop synchronised inside
- bus_en  out  1  drive ebus address and control
- bus_a  out  16  address
- bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n  out  1 each  strobes, active low
- bus_wrdata  out  8  write data
- bus_wrdata_en  out  1  drive ebus_d
- bus_rddata  in  8  ebus_d
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-cycle):
  - bus_busreq=0, bus_en=0, all strobes=1, bus_wrdata_en=0.
  - acks/errs=0, rddata=0, bus_a=0, timers=0.
  - last_grant=1, so port 0 wins first.
- Outputs are registered. Strobes and bus_en are glitch-free.
- States and transitions:
  - IDLE: any pending req -> REQ_BUS; assert bus_busreq.
  - REQ_BUS: synced busack_n=0 -> SETUP with a port selected; counter reaching ACK_TIMEOUT -> FAIL.
  - SETUP (T_SETUP cycles): latch the selected port's addr, wrdata, wr and io on entry. bus_en=1, bus_a valid, mreq_n/iorq_n low per io, wrdata_en=wr.
  - STROBE (T_STROBE cycles): rd_n=!(!wr) or wr_n=!wr, low. For reads, register bus_rddata on the last STROBE cycle.
  - HOLD (T_HOLD cycles): strobes high. mreq_n/iorq_n go high on the last HOLD cycle. Pulse rN_ack for the selected port on the final HOLD cycle. Then: another pending req -> SETUP (bus kept, bus_en stays 1); else -> LINGER.
  - LINGER: bus_en=1, all strobes high, bus_busreq=1. A req arriving -> SETUP with no re-handshake. Idle T_LINGER cycles -> RELEASE.
  - FAIL: pulse ack+err to every port with req high. Then -> RELEASE.
  - RELEASE: bus_en=0 in the first cycle, bus_busreq=0. Wait for synced busack_n=1, then IDLE. Requests are not accepted in RELEASE.
- Selection rule:
  - Evaluated on entry to SETUP.
  - Both requesting: pick !last_grant. Otherwise pick the one requesting.
  - Update last_grant on selection.
- Port masking:
  - A port is masked for the cycle after its ack, so a level req still high from the completed access is not re-accepted.
  - Requesters must drop or renew req within that cycle.
- Changes to rN_addr/wrdata after SETUP entry have no effect until the next access.
- Latency: idle bus, grant already held (LINGER) to ack = T_SETUP+T_STROBE+T_HOLD = 10 cycles. From IDLE, add busack sync (2) plus Z80 response.
- busack_n rising while bus_en=1 is a protocol violation:
  - Abort the current access: ack+err.
  - Deassert everything in the next cycle, then go to RELEASE.
- All counters saturate. Width is clog2 of the largest parameter + 1.

Decomposition:
- Package ebus_pkg:
  - state enum (IDLE, REQ_BUS, SETUP, STROBE, HOLD, LINGER, FAIL, RELEASE)
  - default timing constants
  - requester-index type
- One natural sub-module: ebus_rr_sel. Two-input round-robin selector with last_grant register and post-ack mask.
- Synchroniser stays inline.

Test Plan:
- Port 0 read 0x1234, bench busack_n low 5 cycles after busreq, bus_rddata=0xA5 -> rd_n low exactly 6 cycles, r0_ack once, r0_rddata=0xA5, r0_err=0.
- Port 1 IO write 0x00BF=0x3C, bus already held in LINGER -> no busreq toggle, iorq_n low, wr_n low 6 cycles, wrdata_en window 10 cycles, ack 10 cycles after req.
- Both req simultaneously, repeated 4 accesses each -> grants alternate 0,1,0,1... with port 0 first after reset, a single busreq assertion for the burst, release 16 idle cycles after the last ack.
- busack_n never asserted -> after 1024 cycles, ack+err on all requesting ports, busreq drops, no strobe ever low.
- Reset asserted mid-STROBE -> bus_en, busreq and strobes inactive without waiting for a clk edge; next access starts from IDLE with port 0 priority.
- busack_n deasserted during STROBE -> current port gets ack+err, bus_en=0 next cycle, state returns to IDLE after busack_n stays high.
